// File: rtl/v_countdown_arbiter_pkg.sv
// Shared types and helpers for the round-robin countdown arbiter.
// Holds the FSM state encoding and the index-width function for the LAST and owner registers.
package v_countdown_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

    // A requester index always needs at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/v_countdown_arbiter_if.sv
// Request/grant/counter bundle between the timeout clients (master) and the arbiter (slave).
interface v_countdown_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] load_val;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  busy;
    logic [NREQ-1:0]       done;

    modport master (output req, load_val, input gnt, q, busy, done);
    modport slave  (input req, load_val, output gnt, q, busy, done);
endinterface

// File: rtl/v_countdown_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at LAST+1, LAST+2, ... (mod NREQ).
module v_countdown_arbiter_rr_pick
    import v_countdown_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);

    // Scanning from the farthest candidate back toward LAST+1 lets the nearest one overwrite.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NREQ]) begin
                o_valid = 1'b1;
                o_idx   = IW'((int'(i_last) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/v_countdown_arbiter.sv
// Round-robin arbiter sharing one loadable down counter among NREQ requesters.
// Optional V_COUNTDOWN_ABORT_EN: the owner dropping REQ mid-count aborts the count with no DONE pulse.
module v_countdown_arbiter
    import v_countdown_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  i_c,
    input  logic                  i_r_n,
    v_countdown_arbiter_if.slave  bus
);

    localparam int IW = idx_w(NREQ);

    state_t            r_state, w_state;
    logic [WIDTH-1:0]  r_q, w_q;
    logic [NREQ-1:0]   r_gnt, w_gnt;
    logic [NREQ-1:0]   r_done, w_done;
    logic              r_busy, w_busy;
    logic [IW-1:0]     r_last, w_last;
    logic [IW-1:0]     r_owner, w_owner;
    logic              w_valid;
    logic [IW-1:0]     w_win;

    v_countdown_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_idx   (w_win)
    );

    always_comb begin
        w_state = r_state;
        w_q     = r_q;
        w_gnt   = r_gnt;
        w_done  = '0;
        w_busy  = r_busy;
        w_last  = r_last;
        w_owner = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_state        = S_COUNT;
                    w_gnt          = '0;
                    w_gnt[w_win]   = 1'b1;
                    w_q            = bus.load_val[w_win*WIDTH +: WIDTH];
                    w_busy         = 1'b1;
                    w_owner        = w_win;
                end
            end
            S_COUNT: begin
`ifdef V_COUNTDOWN_ABORT_EN
                if (!bus.req[r_owner]) begin
                    w_state = S_IDLE;
                    w_gnt   = '0;
                    w_q     = '0;
                    w_busy  = 1'b0;
                    w_last  = r_owner;
                end else
`endif
                if (r_q != '0) begin
                    w_q = r_q - WIDTH'(1);
                end else begin
                    // Q stays at 0 through DONE; the grant drops as the pulse goes out.
                    w_state          = S_DONE;
                    w_gnt            = '0;
                    w_done[r_owner]  = 1'b1;
                    w_last           = r_owner;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_gnt   = '0;
                w_q     = '0;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_c) begin
        if (!i_r_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_last  <= IW'(NREQ - 1);
            r_owner <= '0;
        end else begin
            r_state <= w_state;
            r_q     <= w_q;
            r_gnt   <= w_gnt;
            r_done  <= w_done;
            r_busy  <= w_busy;
            r_last  <= w_last;
            r_owner <= w_owner;
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.q    = r_q;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
